bidir_port_ctrl: RTL and testbench
==================================

# bidir_port_ctrl

Parametrised bidirectional pad controller: owns a WIDTH-bit tri-state bus, switches between input (capture) and output (drive) modes under a direction request, and inserts a programmable high-Z turnaround between every direction change so the block and the external agent never drive the bus together. It sits between core logic and an `inout` pin group. It is the generalised successor of the simple `oe`-gated tri-state I/O cell, adding:

- configurable width
- a direction FSM
- a ready/valid transmit handshake
- registered receive capture

## Interface
- `WIDTH`, 8: bus and data width in bits (≥1).
- `TURN_CYCLES`, 2: high-Z cycles inserted on each direction change (≥1).

- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `dir_req`  in  1  1 = request output (drive) mode, 0 = request input mode.
- `tx_data`  in  WIDTH  data to drive.
- `tx_valid`  in  1  `tx_data` valid.
- `tx_ready`  out  1  transfer accepted when `tx_valid && tx_ready`.
- `rx_data`  out  WIDTH  captured bus value.
- `rx_valid`  out  1  `rx_data` is a fresh sample taken in input mode.
- `oe_o`  out  1  block is driving `io_pin` (registered).
- `busy`  out  1  turnaround in progress.
- `io_pin`  inout  WIDTH  `io_pin = oe_o ? out_reg : 'z`.

One clock; reset is synchronous and active-high.

## Operation
**Reset values:** state IN, `out_reg` 0, `rx_data` 0, `rx_valid` 0, `oe_o` 0, `busy` 0, `tx_ready` 0, turn counter 0, bus released.

**States:**

- **IN**
  - Bus released; the capture path samples `io_pin` every cycle.
  - `dir_req`=1 → TURN_OUT, with the counter loaded to TURN_CYCLES-1.
- **TURN_OUT**
  - Bus released; `busy`=1; counter decrements.
  - Counter==0 → OUT.
  - `dir_req`=0 at any point → IN directly (bus never driven, no turnaround needed).
- **OUT**
  - `oe_o`=1; `tx_ready` = `dir_req` (combinational).
  - On handshake, `out_reg` ← `tx_data`; the value appears on the pin the next cycle.
  - Without a handshake, `out_reg` holds and the pin keeps its last value.
  - `dir_req`=0 → TURN_IN, counter loaded. No transfer is accepted in that cycle.
- **TURN_IN**
  - Bus released; `busy`=1; counter decrements.
  - Counter==0 → IN.
  - `dir_req` is ignored until IN is reached. IN then re-evaluates `dir_req`, so a re-request costs a full TURN_OUT.

**Receive:**
- `rx_valid` is 1 only in IN, after the capture pipeline refills. The pipeline is flushed (valid bits cleared) on every entry to IN.
- `rx_data` updates only while `rx_valid` is 1 and holds its last value otherwise.
- Captured data is never the block's own driven value.

**Transmit:**
- `tx_ready`=0 in every state other than OUT.
- `out_reg` survives OUT→IN→OUT round trips. The first drive after re-entry shows the last accepted word until a new handshake.

**Reset mid-operation:** `rst` in any state releases the bus on the next edge (`oe_o`=0) with no turnaround, and forces IN.

## Timing
- `dir_req` 0→1 sampled in IN at edge t:
  - TURN_OUT spans cycles t+1 … t+TURN_CYCLES.
  - `oe_o`=1 and the bus is driven from cycle t+TURN_CYCLES+1.
- `dir_req` 1→0 sampled in OUT at edge t:
  - `oe_o`=0 from t+1.
  - IN from t+TURN_CYCLES+1.
  - First `rx_valid` L cycles after entering IN, where L = capture latency (1, or 2 with the macro).
- Transmit latency: handshake at edge t → pin shows `tx_data` from t+1.
- Receive latency: pin value at edge t → `rx_data` at t+L.

## Configuration
- `BIDIR_SYNC2_EN` defined:
  - Capture path is a two-flop synchroniser (L=2).
  - For asynchronous external agents.
- Undefined:
  - Single capture register (L=1).
  - External agent is assumed synchronous to `clk`.
- Handshake and FSM behaviour are otherwise identical in both builds.

## Structure
- Package `bidir_pkg`:
  - state enum (IN, TURN_OUT, OUT, TURN_IN) and its 2-bit width
  - default WIDTH and TURN_CYCLES constants
  - counter-width function `$clog2(TURN_CYCLES+1)`
- Sub-module `bidir_in_sync`:
  - WIDTH-bit capture stages plus valid pipeline with a flush input
  - holds the macro-dependent stage count

## Test plan
All scenarios use WIDTH=8, TURN_CYCLES=2, no macro unless stated.

1. **Reset:** hold `rst` 3 cycles while the external agent drives 0x3C → `io_pin` reads 0x3C (block Z), `oe_o`=0, `rx_valid`=0, `tx_ready`=0; from 1 cycle after release, `rx_valid`=1 and `rx_data`=0x3C.
2. **Input capture:** external agent drives 0x55, then 0xA5 → `rx_data` follows with 1-cycle latency, and with 2-cycle latency when `BIDIR_SYNC2_EN` is defined.
3. **Switch to output:** agent releases, `dir_req`=1 at t → `busy`=1 for t+1..t+2; `oe_o`=1 at t+3; send 0xF0 with valid → pin=0xF0 one cycle after the handshake; `rx_valid`=0 throughout.
4. **Return to input with back-pressure:** in OUT, drop `dir_req` while `tx_valid`=1 with 0x0F → not accepted; `oe_o`=0 next cycle; 2 Z cycles; `rx_valid` reasserts; re-enter OUT → pin shows 0xF0 until a new handshake.
5. **Aborted request:** `dir_req` pulsed for 1 cycle in IN → TURN_OUT then straight back to IN; `oe_o` never asserted; no contention (no X on `io_pin`).
6. **Mid-drive reset:** assert `rst` in OUT → `oe_o`=0 and bus Z on the next edge; state IN; `out_reg`=0.

Source files
------------

// File: rtl/bidir_pkg.sv
// Shared types and constants for the bidirectional pad controller.
// Contents: direction FSM state enum, default WIDTH / TURN_CYCLES values and
// the turnaround counter width helper.
package bidir_pkg;

  localparam int unsigned StateW            = 2;
  localparam int unsigned DefaultWidth      = 8;
  localparam int unsigned DefaultTurnCycles = 2;

  typedef enum logic [StateW-1:0] {
    StIn      = 2'd0,
    StTurnOut = 2'd1,
    StOut     = 2'd2,
    StTurnIn  = 2'd3
  } state_e;

  // Counter must hold values 0 .. turn_cycles.
  function automatic int unsigned cnt_width(input int unsigned turn_cycles);
    return $clog2(turn_cycles + 1);
  endfunction

endpackage

// File: rtl/bidir_in_sync.sv
// Receive capture path for bidir_port_ctrl.
// Stage count depends on macro BIDIR_SYNC2_EN: defined -> two-flop synchroniser
// (latency 2), undefined -> single capture register (latency 1).
// Ports:
//   clk_i    clock
//   rst_i    synchronous active-high reset (stages and valid bits cleared)
//   en_i     capture enable (bus released, block in input mode)
//   flush_i  clear all valid bits; data stages hold
//   pin_i    raw bus value
//   data_o   last-stage data
//   valid_o  last-stage valid
module bidir_in_sync
  import bidir_pkg::*;
#(
  parameter int unsigned Width = DefaultWidth
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             flush_i,
  input  logic [Width-1:0] pin_i,
  output logic [Width-1:0] data_o,
  output logic             valid_o
);

`ifdef BIDIR_SYNC2_EN
  localparam int unsigned Stages = 2;
`else
  localparam int unsigned Stages = 1;
`endif

  logic [Width-1:0] stage_q [Stages];
  logic [Stages-1:0] vld_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < Stages; i++) begin
        stage_q[i] <= '0;
      end
      vld_q <= '0;
    end else if (flush_i) begin
      vld_q <= '0;
    end else if (en_i) begin
      stage_q[0] <= pin_i;
      vld_q[0]   <= 1'b1;
      // Later stages load only behind valid data so the output never
      // changes to a stale word while valid is low.
      for (int i = 1; i < Stages; i++) begin
        vld_q[i] <= vld_q[i-1];
        if (vld_q[i-1]) begin
          stage_q[i] <= stage_q[i-1];
        end
      end
    end
  end

  assign data_o  = stage_q[Stages-1];
  assign valid_o = vld_q[Stages-1];

endmodule

// File: rtl/bidir_port_ctrl.sv
// Bidirectional pad controller with direction FSM and high-Z turnaround.
// Optional macro BIDIR_SYNC2_EN selects a two-flop receive synchroniser.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   dir_req           1 = request drive mode, 0 = request input mode
//   tx_data/valid/ready  transmit handshake (accepted only in OUT)
//   rx_data/rx_valid  registered capture of io_pin while in IN
//   oe_o              block is driving io_pin (registered)
//   busy              turnaround in progress
//   io_pin            tri-state bus
module bidir_port_ctrl
  import bidir_pkg::*;
#(
  parameter int unsigned WIDTH       = DefaultWidth,
  parameter int unsigned TURN_CYCLES = DefaultTurnCycles
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             dir_req,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             oe_o,
  output logic             busy,
  inout  wire  [WIDTH-1:0] io_pin
);

  localparam int unsigned CntW = cnt_width(TURN_CYCLES);
  localparam logic [CntW-1:0] TurnLoad = CntW'(TURN_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             oe_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    out_d    = out_q;
    tx_ready = 1'b0;
    busy     = 1'b0;
    unique case (state_q)
      StIn: begin
        if (dir_req) begin
          state_d = StTurnOut;
          cnt_d   = TurnLoad;
        end
      end
      StTurnOut: begin
        busy = 1'b1;
        // Bus was never driven, so an abort needs no turnaround.
        if (!dir_req) begin
          state_d = StIn;
        end else if (cnt_q == '0) begin
          state_d = StOut;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StOut: begin
        tx_ready = dir_req;
        if (!dir_req) begin
          state_d = StTurnIn;
          cnt_d   = TurnLoad;
        end else if (tx_valid) begin
          out_d = tx_data;
        end
      end
      StTurnIn: begin
        busy = 1'b1;
        if (cnt_q == '0) begin
          state_d = StIn;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      default: state_d = StIn;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIn;
      cnt_q   <= '0;
      out_q   <= '0;
      oe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      oe_q    <= (state_d == StOut);
    end
  end

  assign oe_o   = oe_q;
  assign io_pin = oe_q ? out_q : {WIDTH{1'bz}};

  // Capture only while staying in IN; any exit or non-IN cycle clears the
  // valid pipeline so rx_valid never leaks into turnaround or drive.
  logic cap_en, cap_flush;
  assign cap_en    = (state_q == StIn);
  assign cap_flush = (state_d != StIn);

  bidir_in_sync #(
    .Width(WIDTH)
  ) u_in_sync (
    .clk_i  (clk),
    .rst_i  (rst),
    .en_i   (cap_en),
    .flush_i(cap_flush),
    .pin_i  (io_pin),
    .data_o (rx_data),
    .valid_o(rx_valid)
  );

endmodule

// File: tb/tb_bidir_port_ctrl.sv
module tb_bidir_port_ctrl;

`ifdef BIDIR_SYNC2_EN
  localparam int L = 2;
`else
  localparam int L = 1;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       dir_req;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       oe_o;
  logic       busy;
  wire  [7:0] io_pin;

  logic       ext_en;
  logic [7:0] ext_drv;
  assign io_pin = ext_en ? ext_drv : 8'hzz;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bidir_port_ctrl #(
    .WIDTH(8),
    .TURN_CYCLES(2)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .dir_req (dir_req),
    .tx_data (tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .rx_data (rx_data),
    .rx_valid(rx_valid),
    .oe_o    (oe_o),
    .busy    (busy),
    .io_pin  (io_pin)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; dir_req = 1'b0; tx_data = 8'h00; tx_valid = 1'b0;
    ext_en = 1'b1; ext_drv = 8'h3C;

    // 1: reset with agent driving
    repeat (3) tick();
    check("rst_pin", io_pin, 8'h3C);
    check("rst_oe", oe_o, 1'b0);
    check("rst_rxv", rx_valid, 1'b0);
    check("rst_txr", tx_ready, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_rxd", rx_data, 8'h00);
    rst = 1'b0;
    repeat (L) tick();
    check("rel_rxv", rx_valid, 1'b1);
    check("rel_rxd", rx_data, 8'h3C);

    // 2: input capture
    ext_drv = 8'h55;
    repeat (L) tick();
    check("cap55", rx_data, 8'h55);
    ext_drv = 8'hA5;
    repeat (L) tick();
    check("capA5", rx_data, 8'hA5);
    check("capA5_v", rx_valid, 1'b1);

    // 3: switch to output
    ext_en = 1'b0;
    dir_req = 1'b1;
    tick();
    check("to1_busy", busy, 1'b1);
    check("to1_oe", oe_o, 1'b0);
    check("to1_rxv", rx_valid, 1'b0);
    check("to1_txr", tx_ready, 1'b0);
    tick();
    check("to2_busy", busy, 1'b1);
    check("to2_oe", oe_o, 1'b0);
    tick();
    check("out_oe", oe_o, 1'b1);
    check("out_busy", busy, 1'b0);
    check("out_txr", tx_ready, 1'b1);
    check("out_pin0", io_pin, 8'h00);
    tx_data = 8'hF0; tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    check("tx_F0", io_pin, 8'hF0);
    check("tx_rxv", rx_valid, 1'b0);
    tick();
    check("hold_F0", io_pin, 8'hF0);

    // 4: drop dir_req with a pending word
    dir_req = 1'b0; tx_data = 8'h0F; tx_valid = 1'b1;
    #1;
    check("drop_txr", tx_ready, 1'b0);
    tick();
    check("ti1_oe", oe_o, 1'b0);
    check("ti1_busy", busy, 1'b1);
    tick();
    check("ti2_busy", busy, 1'b1);
    tick();
    check("in_busy", busy, 1'b0);
    check("in_rxv0", rx_valid, 1'b0);
    tx_valid = 1'b0;
    ext_en = 1'b1; ext_drv = 8'h99;
    repeat (L) tick();
    check("in_rxv1", rx_valid, 1'b1);
    check("in_rx99", rx_data, 8'h99);
    ext_en = 1'b0;
    dir_req = 1'b1;
    repeat (3) tick();
    check("re_oe", oe_o, 1'b1);
    check("re_pinF0", io_pin, 8'hF0);

    // 5: aborted request
    dir_req = 1'b0;
    repeat (3) tick();
    check("ab_in_busy", busy, 1'b0);
    check("ab_in_oe", oe_o, 1'b0);
    dir_req = 1'b1;
    tick();
    check("ab_to_busy", busy, 1'b1);
    dir_req = 1'b0;
    tick();
    check("ab_back_busy", busy, 1'b0);
    check("ab_back_oe", oe_o, 1'b0);
    ext_en = 1'b1; ext_drv = 8'hC3;
    #1;
    check("ab_pin", io_pin, 8'hC3);
    repeat (L) tick();
    check("ab_oe2", oe_o, 1'b0);
    check("ab_rxv", rx_valid, 1'b1);
    check("ab_rxd", rx_data, 8'hC3);

    // 6: reset while driving
    ext_en = 1'b0;
    dir_req = 1'b1;
    repeat (3) tick();
    check("md_oe", oe_o, 1'b1);
    check("md_pin", io_pin, 8'hF0);
    rst = 1'b1;
    tick();
    check("md_rst_oe", oe_o, 1'b0);
    check("md_rst_busy", busy, 1'b0);
    check("md_rst_txr", tx_ready, 1'b0);
    rst = 1'b0;
    repeat (3) tick();
    check("md_re_oe", oe_o, 1'b1);
    check("md_re_pin0", io_pin, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
